energy_sample_logger: RTL

- Downstream consumer of the converter's 8-bit converted-voltage stream.
- Groups samples into fixed windows and computes average, minimum and maximum per window.
- Buffers each window record in a small FIFO.
- Streams records off-chip as framed 8N1 UART telemetry on a single output pin.

---
 rtl/energy_sample_logger_if.sv | 24 ++
 rtl/energy_sample_logger.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/energy_sample_logger_if.sv
// Bundles the sample stream input and the window/telemetry outputs of energy_sample_logger.
interface energy_sample_logger_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              tx;
    logic              tx_busy;
    logic              fifo_full;
    logic [7:0]        overflow_cnt;

    modport master (
        output enable, sample_valid, sample_data,
        input  avg_out, avg_valid, tx, tx_busy, fifo_full, overflow_cnt
    );

    modport slave (
        input  enable, sample_valid, sample_data,
        output avg_out, avg_valid, tx, tx_busy, fifo_full, overflow_cnt
    );
endinterface

// File: rtl/energy_sample_logger.sv
// Windowed avg/min/max of a sample stream, buffered in a record FIFO and sent as 8N1 UART frames.
// Define LOGGER_CHECKSUM_EN to append an avg^min^max checksum byte to every frame.
module energy_sample_logger #(
    parameter int DATA_W     = 8,
    parameter int WIN_LOG2   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    energy_sample_logger_if.slave bus
);
    localparam int ACC_W  = DATA_W + WIN_LOG2;
    localparam int REC_W  = 3 * DATA_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(BAUD_DIV + 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
`ifdef LOGGER_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

    // ---------------- window statistics ----------------
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_min, r_max;
    logic [DATA_W-1:0]   r_avg, r_rec_min, r_rec_max;
    logic                r_avg_valid;
    logic                w_accept, w_first, w_last;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [DATA_W-1:0]   w_min_new, w_max_new;

    assign w_accept  = bus.enable && bus.sample_valid;
    assign w_first   = (r_win_cnt == '0);
    assign w_last    = (r_win_cnt == '1);
    assign w_acc_sum = r_acc + ACC_W'(bus.sample_data);
    assign w_min_new = (w_first || bus.sample_data < r_min) ? bus.sample_data : r_min;
    assign w_max_new = (w_first || bus.sample_data > r_max) ? bus.sample_data : r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_avg       <= '0;
            r_rec_min   <= '0;
            r_rec_max   <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (w_accept) begin
                if (w_last) begin
                    r_win_cnt   <= '0;
                    r_acc       <= '0;
                    r_avg       <= DATA_W'(w_acc_sum >> WIN_LOG2);
                    r_rec_min   <= w_min_new;
                    r_rec_max   <= w_max_new;
                    r_avg_valid <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
                    r_acc     <= w_acc_sum;
                    r_min     <= w_min_new;
                    r_max     <= w_max_new;
                end
            end
        end
    end

    // ---------------- record FIFO ----------------
    // The avg_valid cycle doubles as the push strobe for the record just closed.
    logic [REC_W-1:0] r_mem [FIFO_DEPTH];
    logic [REC_W-1:0] r_frame;
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_fifo_cnt, w_fifo_cnt_next;
    logic             r_fifo_full;
    logic [7:0]       r_ovf_cnt;
    logic             w_push, w_pop, w_push_ok, w_drop;
    state_t           r_state, w_state_next;

    assign w_push    = r_avg_valid;
    assign w_pop     = (r_state == S_LOAD);
    assign w_push_ok = w_push && ((r_fifo_cnt != FULL_CNT) || w_pop);
    assign w_drop    = w_push && !w_push_ok;

    always_comb begin
        w_fifo_cnt_next = r_fifo_cnt;
        if (w_push_ok && !w_pop) begin
            w_fifo_cnt_next = r_fifo_cnt + (PTR_W + 1)'(1);
        end else if (!w_push_ok && w_pop) begin
            w_fifo_cnt_next = r_fifo_cnt - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= {r_avg, r_rec_min, r_rec_max};
        end
        if (w_pop) begin
            r_frame <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fifo_cnt  <= '0;
            r_fifo_full <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_fifo_cnt  <= w_fifo_cnt_next;
            r_fifo_full <= (w_fifo_cnt_next == FULL_CNT);
            if (w_drop && r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    // ---------------- UART serializer ----------------
    logic [BAUD_W-1:0] r_baud, w_baud_next;
    logic [2:0]        r_bit_idx, w_bit_next, w_bit_inc;
    logic [2:0]        r_byte_idx, w_byte_next;
    logic              r_tx, w_tx_next;
    logic              r_tx_busy, w_busy_next;
    logic [7:0]        w_cur_byte;

`ifdef LOGGER_CHECKSUM_EN
    logic [7:0] w_chk;
    assign w_chk = r_frame[REC_W-1 -: DATA_W] ^ r_frame[2*DATA_W-1 -: DATA_W] ^ r_frame[DATA_W-1:0];
`endif

    assign w_bit_inc = r_bit_idx + 3'd1;

    always_comb begin
        w_cur_byte = 8'hA5;
        case (r_byte_idx)
            3'd1:    w_cur_byte = r_frame[REC_W-1 -: DATA_W];
            3'd2:    w_cur_byte = r_frame[2*DATA_W-1 -: DATA_W];
            3'd3:    w_cur_byte = r_frame[DATA_W-1:0];
`ifdef LOGGER_CHECKSUM_EN
            3'd4:    w_cur_byte = w_chk;
`endif
            default: w_cur_byte = 8'hA5;
        endcase
    end

    // tx and tx_busy are registered so each line level lines up with the state it belongs to.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_byte_next  = r_byte_idx;
        w_tx_next    = r_tx;
        w_busy_next  = r_tx_busy;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (r_fifo_cnt != '0) begin
                    w_state_next = S_LOAD;
                    w_busy_next  = 1'b1;
                end
            end
            S_LOAD: begin
                w_byte_next  = '0;
                w_baud_next  = BAUD_LAST;
                w_tx_next    = 1'b0;
                w_state_next = S_START;
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_baud_next  = BAUD_LAST;
                    w_bit_next   = '0;
                    w_tx_next    = w_cur_byte[0];
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (r_baud == '0) begin
                    w_baud_next = BAUD_LAST;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = w_bit_inc;
                        w_tx_next  = w_cur_byte[w_bit_inc];
                    end
                end else begin
                    w_baud_next = r_baud - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (r_baud == '0) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        w_busy_next  = 1'b0;
                        w_tx_next    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_byte_next  = r_byte_idx + 3'd1;
                        w_baud_next  = BAUD_LAST;
                        w_tx_next    = 1'b0;
                        w_state_next = S_START;
                    end
                end else begin
                    w_baud_next = r_baud - BAUD_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_tx       <= w_tx_next;
            r_tx_busy  <= w_busy_next;
        end
    end

    assign bus.avg_out      = r_avg;
    assign bus.avg_valid    = r_avg_valid;
    assign bus.tx           = r_tx;
    assign bus.tx_busy      = r_tx_busy;
    assign bus.fifo_full    = r_fifo_full;
    assign bus.overflow_cnt = r_ovf_cnt;
endmodule
